// File: rtl/vxv_dot_accumulator.sv
// vXv dot-product engine: lane-wise multiply, adder-tree reduce, accumulate over total/NO_OF_UNITS words.
// Each word lands in acc 3 cycles after in_valid; no stalls, words outside RUN/DRAIN or beyond N are dropped.
module vxv_dot_accumulator #(
  parameter int NO_OF_UNITS   = 8,
  parameter int ELEMENT_WIDTH = 32,
  parameter int ACC_WIDTH     = 80,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic                                 in_valid,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] vec_a,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] vec_b,
  output logic                                 read_req,
  output logic                                 busy,
  output logic                                 done,
  output logic [ACC_WIDTH-1:0]                 result,
  output logic [COUNT_WIDTH-1:0]               word_count
);
  localparam int LANE_SHIFT = $clog2(NO_OF_UNITS);
  localparam int PW         = 2 * ELEMENT_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, next_state;

  logic [COUNT_WIDTH-1:0]      n_words, req_count, word_count_q, start_words;
  logic                        accept, s1_vld, s2_vld;
  logic signed [PW-1:0]        prod    [NO_OF_UNITS];
  logic signed [PW-1:0]        s1_prod [NO_OF_UNITS];
  logic signed [ACC_WIDTH-1:0] node    [NO_OF_UNITS];
  logic signed [ACC_WIDTH-1:0] tree_sum, s2_sum, acc, result_q;

  assign start_words = COUNT_WIDTH'(total >> LANE_SHIFT);
  assign accept      = in_valid && (state == RUN || state == DRAIN) && (word_count_q < n_words);

  always_comb begin
    for (int i = 0; i < NO_OF_UNITS; i++) begin
      prod[i] = PW'($signed(vec_a[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]))
              * PW'($signed(vec_b[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]));
    end
  end

  // In-place balanced reduction: each pass halves the live width.
  always_comb begin
    for (int i = 0; i < NO_OF_UNITS; i++) begin
      node[i] = ACC_WIDTH'(s1_prod[i]);
    end
    for (int w = NO_OF_UNITS / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        node[j] = node[2*j] + node[2*j+1];
      end
    end
    tree_sum = node[0];
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (start_words == '0) ? DONE : RUN;
      RUN:     if (req_count == n_words - COUNT_WIDTH'(1)) next_state = DRAIN;
      // S2 folds into acc on this same edge, so acc is final on entering DONE.
      DRAIN:   if (word_count_q == n_words && !s1_vld) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      n_words      <= '0;
      req_count    <= '0;
      word_count_q <= '0;
      s1_vld       <= 1'b0;
      s2_vld       <= 1'b0;
      acc          <= '0;
      result_q     <= '0;
    end else begin
      state  <= next_state;
      s1_vld <= accept;
      s2_vld <= s1_vld;
      if (state == IDLE && start) begin
        n_words      <= start_words;
        req_count    <= '0;
        word_count_q <= '0;
        acc          <= '0;
      end else begin
        if (state == RUN) req_count <= req_count + COUNT_WIDTH'(1);
        if (accept) word_count_q <= word_count_q + COUNT_WIDTH'(1);
        if (s2_vld) acc <= acc + s2_sum;
      end
      if (state == DONE) result_q <= acc;
    end
  end

  always_ff @(posedge clk) begin
    s1_prod <= prod;
    s2_sum  <= tree_sum;
  end

  assign read_req   = (state == RUN);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign result     = (state == DONE) ? acc : result_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_vxv_dot_accumulator.sv
// Directed bench for vxv_dot_accumulator: a memory responder answers read_req after a set delay.
module tb_vxv_dot_accumulator;
  logic         clk = 1'b0;
  logic         reset, start, in_valid;
  logic [31:0]  total;
  logic [255:0] vec_a, vec_b;
  logic         read_req, busy, done;
  logic [79:0]  result;
  logic [31:0]  word_count;

  int n_tests = 0;
  int n_fail  = 0;

  int          reqs, dones, done_cyc, last_iv;
  logic [79:0] res;
  logic [31:0] wc;
  logic        busy_after;

  vxv_dot_accumulator dut (
    .clk(clk), .reset(reset), .start(start), .total(total), .in_valid(in_valid),
    .vec_a(vec_a), .vec_b(vec_b), .read_req(read_req), .busy(busy), .done(done),
    .result(result), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++) begin
      vec_a[i*32 +: 32] = a;
      vec_b[i*32 +: 32] = b;
    end
  endtask

  // Cycle 0 is the start cycle; returns positioned on the cycle after done.
  task automatic run_op(input int tot, input int delay, input int extra, input bit start_on_done,
                        output int o_reqs, output int o_dones, output int o_done_cyc,
                        output int o_last_iv, output logic [79:0] o_res, output logic [31:0] o_wc,
                        output logic o_busy_after);
    int due[$];
    int last_due;
    bit seen, prev_req;
    o_reqs = 0; o_dones = 0; o_done_cyc = -1; o_last_iv = -1;
    o_res = '0; o_wc = '0; o_busy_after = 1'b1;
    seen = 0; prev_req = 0; last_due = 0;
    total = tot;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 100 && !seen; cyc++) begin
      if (read_req) begin
        o_reqs++;
        last_due = cyc + delay;
        due.push_back(last_due);
      end else if (prev_req) begin
        for (int k = 0; k < extra; k++) due.push_back(last_due + 1 + k);
      end
      prev_req = read_req;
      in_valid = (due.size() > 0 && due[0] == cyc);
      if (in_valid) begin
        void'(due.pop_front());
        o_last_iv = cyc;
      end
      if (done) begin
        o_dones++;
        o_done_cyc = cyc;
        o_res = result;
        o_wc = word_count;
        seen = 1;
        if (start_on_done) start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (!seen) check("done_timeout", 1'b0, 1'b1);
    o_busy_after = busy;
    if (done) o_dones++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; total = '0;
    vec_a = '0; vec_b = '0;
    tick();
    tick();
    check("rst_read_req", read_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 80'd0);
    check("rst_word_count", word_count, 32'd0);
    reset = 1'b0;
    tick();

    // Basic: 2 words, 8 lanes of 1*2 each
    set_lanes(32'd1, 32'd2);
    run_op(16, 1, 0, 0, reqs, dones, done_cyc, last_iv, res, wc, busy_after);
    check("basic_reqs", reqs, 2);
    check("basic_dones", dones, 1);
    check("basic_result", res, 80'd32);
    check("basic_wc", wc, 32'd2);
    check("basic_busy_after", busy_after, 1'b0);
    check("basic_latency", done_cyc - last_iv, 3);

    // Signed with long upstream delay: sum of -(i+1)*3
    for (int i = 0; i < 8; i++) begin
      vec_a[i*32 +: 32] = -(i + 1);
      vec_b[i*32 +: 32] = 32'd3;
    end
    run_op(8, 4, 0, 0, reqs, dones, done_cyc, last_iv, res, wc, busy_after);
    check("signed_result", res, -80'sd108);
    check("signed_latency", done_cyc - last_iv, 3);
    check("signed_reqs", reqs, 1);

    // Zero words after floor: straight to DONE, acc cleared
    run_op(7, 1, 0, 0, reqs, dones, done_cyc, last_iv, res, wc, busy_after);
    check("zero_reqs", reqs, 0);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_result", res, 80'd0);

    set_lanes(32'd1, 32'd1);
    run_op(12, 1, 0, 0, reqs, dones, done_cyc, last_iv, res, wc, busy_after);
    check("rem_reqs", reqs, 1);
    check("rem_result", res, 80'd8);

    // in_valid while idle must not touch counters or result
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("idle_iv_wc", word_count, 32'd1);
    check("idle_iv_result", result, 80'd8);
    check("idle_iv_busy", busy, 1'b0);

    // One extra word beyond N dropped; start in the done cycle ignored
    run_op(16, 1, 1, 1, reqs, dones, done_cyc, last_iv, res, wc, busy_after);
    check("extra_result", res, 80'd16);
    check("extra_wc", wc, 32'd2);
    check("done_start_busy", busy_after, 1'b0);
    tick();
    tick();
    check("done_start_busy_later", busy, 1'b0);
    check("done_start_no_req", read_req, 1'b0);

    // Reset mid-run after 3 accepted words
    total = 64;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    check("midrst_wc_pre", word_count, 32'd3);
    reset = 1'b1;
    tick();
    check("midrst_read_req", read_req, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 80'd0);
    check("midrst_wc", word_count, 32'd0);
    reset = 1'b0;
    tick();
    run_op(8, 1, 0, 0, reqs, dones, done_cyc, last_iv, res, wc, busy_after);
    check("postrst_result", res, 80'd8);

    // Back-to-back at max positive lanes: 8*(2^31-1)^2 = 2^65 - 2^35 + 8
    set_lanes(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_op(8, 1, 0, 0, reqs, dones, done_cyc, last_iv, res, wc, busy_after);
    check("max1_result", res, 80'h1_FFFF_FFF8_0000_0008);
    check("max1_busy_after", busy_after, 1'b0);
    run_op(8, 2, 0, 0, reqs, dones, done_cyc, last_iv, res, wc, busy_after);
    check("max2_result", res, 80'h1_FFFF_FFF8_0000_0008);
    check("max2_dones", dones, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
